// File: rtl/microtile_tdc_pkg.sv
// Shared types and constants for the coarse counter TDC microtile.
package microtile_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } tdc_state_e;

  typedef enum logic [1:0] {
    SEL_RES_LO = 2'd0,
    SEL_RES_HI = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_MEAS   = 2'd3
  } out_sel_e;

  localparam int UI_START  = 0;
  localparam int UI_STOP   = 1;
  localparam int UI_ARM    = 2;
  localparam int UI_CLEAR  = 3;
  localparam int UI_SEL_LO = 4;
  localparam int UI_SEL_HI = 5;

  localparam int ST_STATE_MSB = 7;
  localparam int ST_STATE_LSB = 6;
  localparam int ST_OVF       = 5;
  localparam int ST_VALID     = 4;

  function automatic logic [7:0] status_byte(tdc_state_e s, logic ovf, logic vld);
    logic [7:0] b;
    b = '0;
    b[ST_STATE_MSB:ST_STATE_LSB] = s;
    b[ST_OVF]   = ovf;
    b[ST_VALID] = vld;
    return b;
  endfunction

endpackage

// File: rtl/microtile_tdc_counter_if.sv
// Microtile pad bus: ui_in from the container, uo_out back to its mux.
interface microtile_tdc_counter_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ui_in, input uo_out);
  modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/tdc_sync_edge.sv
// Pad synchronizer + rise detector; FILTER requires two high cycles before
// a pulse is issued, which rejects single-cycle glitches at +1 latency.
module tdc_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit FILTER      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic lvl_d1, lvl_d2;
  logic lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_d1 <= 1'b0;
      lvl_d2 <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      lvl_d1 <= lvl;
      lvl_d2 <= lvl_d1;
      pulse  <= FILTER ? (lvl & lvl_d1 & ~lvl_d2) : (lvl & ~lvl_d1);
    end
  end

endmodule

// File: rtl/microtile_tdc_counter.sv
// Coarse TDC microtile: cycles between start and stop pulses, byte readout.
// Optional: define TDC_GLITCH_FILTER_EN to filter start/stop glitches.
module microtile_tdc_counter
  import microtile_tdc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  microtile_tdc_counter_if.slave bus
);

`ifdef TDC_GLITCH_FILTER_EN
  localparam bit EDGE_FILT = 1'b1;
`else
  localparam bit EDGE_FILT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] pulse;
  logic start_p, stop_p, arm_p, clr_p;

  // bits 0..3 of ui_in are start, stop, arm, clear; only start/stop filter
  for (genvar i = 0; i < 4; i++) begin : g_sync
    tdc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER     ((i < 2) ? EDGE_FILT : 1'b0)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bus.ui_in[i]),
      .pulse(pulse[i])
    );
  end

  assign start_p = pulse[UI_START];
  assign stop_p  = pulse[UI_STOP];
  assign arm_p   = pulse[UI_ARM];
  assign clr_p   = pulse[UI_CLEAR];

  tdc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, result_q, result_d;
  logic             ovf_q, ovf_d, valid_q, valid_d;
  logic [7:0]       meas_q, meas_d, uo_q, uo_d;
  logic [15:0]      res16;
  logic             unused_ui;

  assign unused_ui = ^bus.ui_in[7:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      meas_q   <= '0;
      uo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      meas_q   <= meas_d;
      uo_q     <= uo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    meas_d   = meas_q;
    if (clr_p) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
      ovf_d    = 1'b0;
      valid_d  = 1'b0;
      meas_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (arm_p) begin
          state_d = ARMED;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
        end
        ARMED: if (start_p) begin
          cnt_d = '0;
          if (stop_p) begin
            state_d  = DONE;
            result_d = '0;
            valid_d  = 1'b1;
            meas_d   = meas_q + 8'd1;
          end else begin
            state_d = RUNNING;
          end
        end
        RUNNING: begin
          // a stop landing on the saturating cycle cannot be represented either
          if (cnt_q == CNT_MAX) begin
            state_d  = DONE;
            result_d = CNT_MAX;
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            meas_d   = meas_q + 8'd1;
          end else if (stop_p) begin
            state_d  = DONE;
            result_d = cnt_q + 1'b1;
            valid_d  = 1'b1;
            meas_d   = meas_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: if (arm_p) begin
          state_d = ARMED;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign res16 = 16'(result_q);

  always_comb begin
    uo_d = '0;
    unique case (out_sel_e'(bus.ui_in[UI_SEL_HI:UI_SEL_LO]))
      SEL_RES_LO: uo_d = res16[7:0];
      SEL_RES_HI: uo_d = res16[15:8];
      SEL_STATUS: uo_d = status_byte(state_q, ovf_q, valid_q);
      SEL_MEAS:   uo_d = meas_q;
      default:    uo_d = '0;
    endcase
  end

  assign bus.uo_out = uo_q;

endmodule
